hazard_ctrl: RTL

//  Pipeline sequencer for the 5-stage 18-bit core: forwarding selects for the E-stage ALU operands,

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_ctrl_fwd_sel.sv | 28 ++
 rtl/hazard_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   hz_state_t : sequencer states (RUN, BR_FLUSH, MEM_WAIT)
//   FWD_*      : E-stage ALU operand forwarding select encodings
//   sat_inc16  : 16-bit increment that holds at all-ones
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_FLUSH = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one E-stage source register.
// Ports:
//   rs          in  5  source register of the E instruction
//   rd_m, rd_w  in  5  destination registers in M and W
//   reg_write_m in  1  M instruction writes the register file
//   reg_write_w in  1  W instruction writes the register file
//   fwd         out 2  FWD_M / FWD_W / FWD_RF (M wins over W, r0 never forwarded)
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      fwd = FWD_M;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage 18-bit core: operand forwarding,
// load-use stalls, taken-branch flush sequencing and data-memory wait freezes.
// Optional perf counters are built only when HAZARD_PERF_EN is defined;
// otherwise stall_cnt/flush_cnt/wait_cnt are tied to zero.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   RS1_D, RS2_D, RS1_E, RS2_E        source registers in D and E
//   RD_E, RD_M, RD_W                  destination registers in E/M/W
//   ResultSrcE, RegWriteM, RegWriteW  load-in-E, RF write flags in M/W
//   PCSrcE                            branch in E resolved taken
//   MemReqM, MemReadyM                data memory request / completion
//   StallF/D/E/M, FlushD/E            stage hold and bubble controls
//   ForwardAE, ForwardBE              operand forwarding selects
//   MemErr                            sticky memory timeout flag
//   stall_cnt, flush_cnt, wait_cnt    perf counters
//   state_dbg                         current sequencer state
// Handshake: a memory access is outstanding in any cycle with MemReqM=1 and
// MemReadyM=0; the cycle MemReadyM=1 is the completion cycle and is still frozen.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int BR_PENALTY  = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  RS1_D,
  input  logic [4:0]  RS2_D,
  input  logic [4:0]  RS1_E,
  input  logic [4:0]  RS2_E,
  input  logic [4:0]  RD_E,
  input  logic [4:0]  RD_M,
  input  logic [4:0]  RD_W,
  input  logic        ResultSrcE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        PCSrcE,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        MemErr,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [15:0] wait_cnt,
  output logic [1:0]  state_dbg
);

  localparam logic [2:0] BR_REM_INIT = 3'(BR_PENALTY - 1);
  // Last timer value at which a missing ready forces release; the RUN cycle
  // that starts the wait counts as wait cycle 1.
  localparam logic [7:0] TO_LAST     = 8'(MEM_TIMEOUT - 1);

  hz_state_t  state_q, state_d;
  logic [2:0] rem_q, rem_d;
  logic [7:0] timer_q, timer_d;
  logic       mem_err_q, mem_err_d;
  logic       mem_stall, load_use;
  logic       stall_all, load_stall, flush_d, flush_e;

  fwd_sel u_fwd_a (.rs(RS1_E), .rd_m(RD_M), .rd_w(RD_W), .reg_write_m(RegWriteM),
                   .reg_write_w(RegWriteW), .fwd(ForwardAE));
  fwd_sel u_fwd_b (.rs(RS2_E), .rd_m(RD_M), .rd_w(RD_W), .reg_write_m(RegWriteM),
                   .reg_write_w(RegWriteW), .fwd(ForwardBE));

  assign mem_stall = MemReqM && !MemReadyM;
  assign load_use  = ResultSrcE && (RD_E != 5'd0) && ((RD_E == RS1_D) || (RD_E == RS2_D));

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    timer_d    = timer_q;
    mem_err_d  = mem_err_q;
    stall_all  = 1'b0;
    load_stall = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          stall_all = 1'b1;
          state_d   = MEM_WAIT;
          timer_d   = 8'd1;
          rem_d     = 3'd0;
        end else if (PCSrcE) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
          if (BR_PENALTY > 1) begin
            state_d = BR_FLUSH;
            rem_d   = BR_REM_INIT;
          end
        end else if (load_use) begin
          load_stall = 1'b1;
        end
      end
      BR_FLUSH: begin
        if (mem_stall) begin
          // Freeze first; the untouched rem_q resumes the flush afterwards.
          stall_all = 1'b1;
          state_d   = MEM_WAIT;
          timer_d   = 8'd1;
        end else begin
          flush_d = 1'b1;
          if (rem_q <= 3'd1) begin
            rem_d   = 3'd0;
            state_d = RUN;
          end else begin
            rem_d = rem_q - 3'd1;
          end
        end
      end
      MEM_WAIT: begin
        stall_all = 1'b1;
        if (MemReadyM || (timer_q >= TO_LAST)) begin
          if (!MemReadyM) mem_err_d = 1'b1;
          timer_d = 8'd0;
          state_d = (rem_q != 3'd0) ? BR_FLUSH : RUN;
        end else if (timer_q != 8'hFF) begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      rem_q     <= 3'd0;
      timer_q   <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      timer_q   <= timer_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign StallF    = stall_all | load_stall;
  assign StallD    = stall_all | load_stall;
  assign StallE    = stall_all;
  assign StallM    = stall_all;
  assign FlushD    = flush_d;
  assign FlushE    = flush_e | load_stall;
  assign MemErr    = mem_err_q;
  assign state_dbg = state_q;

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q, flush_cnt_q, wait_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
      wait_cnt_q  <= 16'd0;
    end else begin
      if (StallD)                stall_cnt_q <= sat_inc16(stall_cnt_q);
      if (FlushD || FlushE)      flush_cnt_q <= sat_inc16(flush_cnt_q);
      if (state_q == MEM_WAIT)   wait_cnt_q  <= sat_inc16(wait_cnt_q);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign wait_cnt  = wait_cnt_q;
`else
  assign stall_cnt = 16'd0;
  assign flush_cnt = 16'd0;
  assign wait_cnt  = 16'd0;
`endif

endmodule
